// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multicycle controller: FSM states,
// instruction classes, opcode values and datapath select codes.
package multicycle_pkg;

  localparam int unsigned OPCODE_W = 6;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
    S_EXEC_R, S_R_WB, S_EXEC_I, S_I_WB, S_BRANCH, S_JUMP, S_TRAP
  } state_e;

  typedef enum logic [3:0] {
    CLS_RTYPE, CLS_LW, CLS_SW, CLS_BEQ, CLS_BNE, CLS_JUMP,
    CLS_ADDI, CLS_ANDI, CLS_ORI, CLS_SLTI, CLS_ILLEGAL
  } instr_class_e;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OPCODE_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OPCODE_W-1:0] OP_SLTI  = 6'b001010;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SHL = 2'b11;

endpackage

// File: rtl/multicycle_opdecode.sv
// Combinational opcode classifier: maps the IR opcode field to an
// instruction class and flags anything unsupported as illegal.
module multicycle_opdecode
  import multicycle_pkg::*;
#(
  parameter int unsigned OPWIDTH = 6
) (
  input  logic [OPWIDTH-1:0] opcode_i,
  output instr_class_e       class_o,
  output logic               legal_o
);

  // Opcode lookup; unknown encodings fall through to the illegal class
  always_comb begin
    class_o = CLS_ILLEGAL;
    case (opcode_i)
      OPWIDTH'(OP_RTYPE): class_o = CLS_RTYPE;
      OPWIDTH'(OP_LW):    class_o = CLS_LW;
      OPWIDTH'(OP_SW):    class_o = CLS_SW;
      OPWIDTH'(OP_BEQ):   class_o = CLS_BEQ;
      OPWIDTH'(OP_BNE):   class_o = CLS_BNE;
      OPWIDTH'(OP_J):     class_o = CLS_JUMP;
      OPWIDTH'(OP_ADDI):  class_o = CLS_ADDI;
      OPWIDTH'(OP_ANDI):  class_o = CLS_ANDI;
      OPWIDTH'(OP_ORI):   class_o = CLS_ORI;
      OPWIDTH'(OP_SLTI):  class_o = CLS_SLTI;
      default:            class_o = CLS_ILLEGAL;
    endcase
    legal_o = (class_o != CLS_ILLEGAL);
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS-style control FSM with run/step control, sticky illegal
// opcode trap and optional performance counters (MULTICYCLE_PERF_EN).
module multicycle_controller
  import multicycle_pkg::*;
#(
  parameter int unsigned OPWIDTH    = 6,
  parameter int unsigned FUNCTWIDTH = 6,
  parameter int unsigned CNTWIDTH   = 32
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  Run,
  input  logic                  StepMode,
  input  logic                  Step,
  input  logic [OPWIDTH-1:0]    Opcode,
  input  logic [FUNCTWIDTH-1:0] Funct,
  input  logic                  MemReady,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic                  IorD,
  output logic                  MemtoReg,
  output logic                  IRWrite,
  output logic                  ALUSrcA,
  output logic                  RegWrite,
  output logic                  RegDst,
  output logic                  PCWrite,
  output logic                  PCWriteCondition_0,
  output logic                  PCWriteCondition_1,
  output logic [1:0]            PCSource,
  output logic [1:0]            ALUSrcB,
  output logic [2:0]            ALUOp,
  output logic                  Halted,
  output logic                  Illegal,
  output logic [CNTWIDTH-1:0]   InstrCount,
  output logic [CNTWIDTH-1:0]   CycleCount
);

  state_e       state_q, state_d;
  logic         illegal_q;
  instr_class_e cls;
  logic         legal;
  logic         instr_end_c;
  state_e       end_next_c;

  // Funct is consumed by the external ALU control, not by the FSM
  logic unused_funct;
  assign unused_funct = ^Funct;

  multicycle_opdecode #(.OPWIDTH(OPWIDTH)) u_opdecode (
    .opcode_i (Opcode),
    .class_o  (cls),
    .legal_o  (legal)
  );

  assign end_next_c = (Run && !StepMode) ? S_FETCH : S_IDLE;
  assign Illegal    = illegal_q;

  // Next-state and Moore outputs; only FETCH IRWrite/PCWrite follow MemReady
  always_comb begin
    state_d            = state_q;
    instr_end_c        = 1'b0;
    MemRead            = 1'b0;
    MemWrite           = 1'b0;
    IorD               = 1'b0;
    MemtoReg           = 1'b0;
    IRWrite            = 1'b0;
    ALUSrcA            = 1'b0;
    RegWrite           = 1'b0;
    RegDst             = 1'b0;
    PCWrite            = 1'b0;
    PCWriteCondition_0 = 1'b0;
    PCWriteCondition_1 = 1'b0;
    PCSource           = PC_ALU;
    ALUSrcB            = SRCB_B;
    ALUOp              = ALU_ADD;
    Halted             = 1'b0;
    case (state_q)
      S_IDLE: begin
        Halted = 1'b1;
        if (Run && (!StepMode || Step)) state_d = S_FETCH;
      end
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        if (MemReady) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcB = SRCB_IMM_SHL;
        if (!legal) begin
          state_d = S_TRAP;
        end else begin
          case (cls)
            CLS_RTYPE:        state_d = S_EXEC_R;
            CLS_LW, CLS_SW:   state_d = S_MEM_ADDR;
            CLS_BEQ, CLS_BNE: state_d = S_BRANCH;
            CLS_JUMP:         state_d = S_JUMP;
            default:          state_d = S_EXEC_I;
          endcase
        end
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        state_d = (cls == CLS_SW) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
        if (MemReady) state_d = S_MEM_WB;
      end
      S_MEM_WRITE: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        if (MemReady) begin
          instr_end_c = 1'b1;
          state_d     = end_next_c;
        end
      end
      S_MEM_WB: begin
        MemtoReg    = 1'b1;
        RegWrite    = 1'b1;
        instr_end_c = 1'b1;
        state_d     = end_next_c;
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALU_FUNCT;
        state_d = S_R_WB;
      end
      S_R_WB: begin
        RegDst      = 1'b1;
        RegWrite    = 1'b1;
        instr_end_c = 1'b1;
        state_d     = end_next_c;
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        case (cls)
          CLS_ANDI: ALUOp = ALU_AND;
          CLS_ORI:  ALUOp = ALU_OR;
          CLS_SLTI: ALUOp = ALU_SLT;
          default:  ALUOp = ALU_ADD;
        endcase
        state_d = S_I_WB;
      end
      S_I_WB: begin
        RegWrite    = 1'b1;
        instr_end_c = 1'b1;
        state_d     = end_next_c;
      end
      S_BRANCH: begin
        ALUSrcA            = 1'b1;
        ALUOp              = ALU_SUB;
        PCSource           = PC_ALUOUT;
        PCWriteCondition_0 = (cls == CLS_BEQ);
        PCWriteCondition_1 = (cls == CLS_BNE);
        instr_end_c        = 1'b1;
        state_d            = end_next_c;
      end
      S_JUMP: begin
        PCSource    = PC_JUMP;
        PCWrite     = 1'b1;
        instr_end_c = 1'b1;
        state_d     = end_next_c;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
  end

  // State register and sticky illegal flag
  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == S_TRAP) illegal_q <= 1'b1;
    end
  end

`ifdef MULTICYCLE_PERF_EN
  logic [CNTWIDTH-1:0] instr_cnt_q, cycle_cnt_q;

  // Free-running wrap-around counters of retired instructions and busy cycles
  always_ff @(posedge CLK) begin
    if (!reset) begin
      instr_cnt_q <= '0;
      cycle_cnt_q <= '0;
    end else begin
      if (instr_end_c) instr_cnt_q <= instr_cnt_q + CNTWIDTH'(1);
      if (state_q != S_IDLE && state_q != S_TRAP)
        cycle_cnt_q <= cycle_cnt_q + CNTWIDTH'(1);
    end
  end

  assign InstrCount = instr_cnt_q;
  assign CycleCount = cycle_cnt_q;
`else
  logic unused_instr_end;
  assign unused_instr_end = instr_end_c;
  assign InstrCount = '0;
  assign CycleCount = '0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller. Each instruction is expanded
// from its opcode and memory wait counts into an expected per-cycle output
// trace; counters are checked at instruction boundaries (MULTICYCLE_PERF_EN).
module tb_multicycle_controller;

  localparam int unsigned CW = 4;

  logic CLK, reset, Run, StepMode, Step, MemReady;
  logic [5:0] Opcode, Funct;
  logic MemRead, MemWrite, IorD, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst;
  logic PCWrite, PCWriteCondition_0, PCWriteCondition_1, Halted, Illegal;
  logic [1:0] PCSource, ALUSrcB;
  logic [2:0] ALUOp;
  logic [CW-1:0] InstrCount, CycleCount;

  multicycle_controller #(.OPWIDTH(6), .FUNCTWIDTH(6), .CNTWIDTH(CW)) dut (
    .CLK(CLK), .reset(reset), .Run(Run), .StepMode(StepMode), .Step(Step),
    .Opcode(Opcode), .Funct(Funct), .MemReady(MemReady),
    .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite), .RegDst(RegDst),
    .PCWrite(PCWrite), .PCWriteCondition_0(PCWriteCondition_0),
    .PCWriteCondition_1(PCWriteCondition_1), .PCSource(PCSource),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .Halted(Halted), .Illegal(Illegal),
    .InstrCount(InstrCount), .CycleCount(CycleCount)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Output vector layout used by the expected traces
  localparam logic [19:0] B_MR   = 20'h80000;
  localparam logic [19:0] B_MW   = 20'h40000;
  localparam logic [19:0] B_IORD = 20'h20000;
  localparam logic [19:0] B_M2R  = 20'h10000;
  localparam logic [19:0] B_IRW  = 20'h08000;
  localparam logic [19:0] B_ASA  = 20'h04000;
  localparam logic [19:0] B_RW   = 20'h02000;
  localparam logic [19:0] B_RD   = 20'h01000;
  localparam logic [19:0] B_PCW  = 20'h00800;
  localparam logic [19:0] B_C0   = 20'h00400;
  localparam logic [19:0] B_C1   = 20'h00200;
  localparam logic [19:0] B_H    = 20'h00002;
  localparam logic [19:0] B_ILL  = 20'h00001;

  logic [19:0] obs;
  assign obs = {MemRead, MemWrite, IorD, MemtoReg, IRWrite, ALUSrcA, RegWrite,
                RegDst, PCWrite, PCWriteCondition_0, PCWriteCondition_1,
                PCSource, ALUSrcB, ALUOp, Halted, Illegal};

  int n_tests = 0;
  int n_fail  = 0;
  int exp_ic  = 0;
  int exp_cc  = 0;
  logic [20:0] q[$];
  logic [5:0] ops [10];

  function automatic logic [19:0] f(input logic [19:0] flags, input logic [1:0] pcs,
                                    input logic [1:0] asb, input logic [2:0] aop);
    return flags | {11'b0, pcs, asb, aop, 2'b00};
  endfunction

  function automatic void add(input logic mr, input logic [19:0] o);
    q.push_back({mr, o});
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(1));
  endfunction

  task automatic chk(input string tag, input logic [19:0] e);
    n_tests++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, e);
    end
  endtask

  // One cycle: drive inputs, compare at the falling edge, advance past posedge
  task automatic cyc(input string tag, input logic mr, input logic [19:0] e);
    MemReady = mr;
    Funct    = 6'($urandom);
    @(negedge CLK);
    chk(tag, e);
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_cnt(input string tag);
    logic [CW-1:0] ei, ec;
`ifdef MULTICYCLE_PERF_EN
    ei = CW'(exp_ic);
    ec = CW'(exp_cc);
`else
    ei = '0;
    ec = '0;
`endif
    n_tests++;
    assert (InstrCount === ei) else begin
      n_fail++;
      $error("FAIL %s.instr: observed %0d expected %0d", tag, InstrCount, ei);
    end
    n_tests++;
    assert (CycleCount === ec) else begin
      n_fail++;
      $error("FAIL %s.cycle: observed %0d expected %0d", tag, CycleCount, ec);
    end
  endtask

  task automatic play(input string tag, input int drop_at);
    for (int i = 0; i < q.size(); i++) begin
      if (i == drop_at) Run = 1'b0;
      cyc(tag, q[i][20], q[i][19:0]);
    end
  endtask

  // Expected trace of one instruction from fetch to its final cycle
  task automatic build(input logic [5:0] op, input int fw, input int mw);
    q.delete();
    for (int i = 0; i < fw; i++) add(1'b0, f(B_MR, 2'b00, 2'b01, 3'b000));
    add(1'b1, f(B_MR | B_IRW | B_PCW, 2'b00, 2'b01, 3'b000));
    add(rb(), f(20'h0, 2'b00, 2'b11, 3'b000));
    case (op)
      6'h23: begin
        add(rb(), f(B_ASA, 2'b00, 2'b10, 3'b000));
        for (int i = 0; i < mw; i++) add(1'b0, f(B_MR | B_IORD, 2'b00, 2'b00, 3'b000));
        add(1'b1, f(B_MR | B_IORD, 2'b00, 2'b00, 3'b000));
        add(rb(), f(B_M2R | B_RW, 2'b00, 2'b00, 3'b000));
      end
      6'h2b: begin
        add(rb(), f(B_ASA, 2'b00, 2'b10, 3'b000));
        for (int i = 0; i < mw; i++) add(1'b0, f(B_MW | B_IORD, 2'b00, 2'b00, 3'b000));
        add(1'b1, f(B_MW | B_IORD, 2'b00, 2'b00, 3'b000));
      end
      6'h00: begin
        add(rb(), f(B_ASA, 2'b00, 2'b00, 3'b010));
        add(rb(), f(B_RW | B_RD, 2'b00, 2'b00, 3'b000));
      end
      6'h04: add(rb(), f(B_ASA | B_C0, 2'b01, 2'b00, 3'b001));
      6'h05: add(rb(), f(B_ASA | B_C1, 2'b01, 2'b00, 3'b001));
      6'h02: add(rb(), f(B_PCW, 2'b10, 2'b00, 3'b000));
      default: begin
        add(rb(), f(B_ASA, 2'b00, 2'b10,
                    (op == 6'h0c) ? 3'b011 : (op == 6'h0d) ? 3'b100 :
                    (op == 6'h0a) ? 3'b101 : 3'b000));
        add(rb(), f(B_RW, 2'b00, 2'b00, 3'b000));
      end
    endcase
  endtask

  task automatic run_instr(input string tag, input logic [5:0] op, input int fw,
                           input int mw, input int drop_at);
    Opcode = op;
    build(op, fw, mw);
    play(tag, drop_at);
    exp_ic += 1;
    exp_cc += q.size();
    chk_cnt(tag);
  endtask

  task automatic do_reset();
    reset = 1'b0; Run = 1'b0; StepMode = 1'b0; Step = 1'b0; MemReady = 1'b0;
    @(posedge CLK);
    #1;
    exp_ic = 0;
    exp_cc = 0;
    @(negedge CLK);
    chk("reset", B_H);
    chk_cnt("reset");
    @(posedge CLK);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    ops = '{6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h00, 6'h08, 6'h0c, 6'h0d, 6'h0a};
    reset = 1'b0; Run = 1'b0; StepMode = 1'b0; Step = 1'b0; MemReady = 1'b0;
    Opcode = 6'h00; Funct = 6'h00;

    // Reset, then halted while Run is low
    do_reset();
    for (int i = 0; i < 3; i++) cyc("halt_run0", rb(), B_H);
    Run = 1'b1;
    cyc("idle_go", 1'b0, B_H);

    // lw with fetch and memory stalls, then beq with ready memory
    run_instr("lw_stall", 6'h23, 3, 2, -1);
    run_instr("beq", 6'h04, 0, 0, -1);

    // Random legal instruction stream
    for (int n = 0; n < 40; n++)
      run_instr("rand", ops[$urandom_range(9)], $urandom_range(3), $urandom_range(3), -1);

    // Run dropped mid-instruction completes it, then halts
    run_instr("run_drop", 6'h00, 1, 0, 3);
    for (int i = 0; i < 3; i++) cyc("halt_after_drop", rb(), B_H);

    // Single-step mode: two released R-type instructions
    do_reset();
    StepMode = 1'b1; Run = 1'b1;
    for (int i = 0; i < 5; i++) cyc("step_wait", rb(), B_H);
    Step = 1'b1;
    cyc("step_pulse1", 1'b0, B_H);
    Step = 1'b0;
    run_instr("step_r1", 6'h00, 0, 0, -1);
    for (int i = 0; i < 10; i++) cyc("step_between", rb(), B_H);
    Step = 1'b1;
    cyc("step_pulse2", 1'b0, B_H);
    Step = 1'b0;
    run_instr("step_r2", 6'h00, 1, 0, -1);
    for (int i = 0; i < 3; i++) cyc("step_after", rb(), B_H);

    // Illegal opcode traps until reset
    do_reset();
    Run = 1'b1;
    cyc("trap_go", 1'b0, B_H);
    Opcode = 6'h3f;
    q.delete();
    add(1'b1, f(B_MR | B_IRW | B_PCW, 2'b00, 2'b01, 3'b000));
    add(rb(), f(20'h0, 2'b00, 2'b11, 3'b000));
    for (int i = 0; i < 6; i++) add(rb(), B_ILL);
    play("trap", -1);
    exp_cc += 2;
    chk_cnt("trap");
    do_reset();

    // Reset during a stalled store drops MemWrite on the next cycle
    Run = 1'b1;
    cyc("sw_go", 1'b0, B_H);
    Opcode = 6'h2b;
    build(6'h2b, 0, 2);
    void'(q.pop_back());
    play("sw_stall", -1);
    reset = 1'b0;
    cyc("sw_reset_cycle", 1'b0, f(B_MW | B_IORD, 2'b00, 2'b00, 3'b000));
    exp_ic = 0;
    exp_cc = 0;
    cyc("sw_after_reset", 1'b1, B_H);
    chk_cnt("sw_after_reset");
    reset = 1'b1;

    // 17 jumps wrap a 4-bit instruction counter to 1
    do_reset();
    Run = 1'b1;
    cyc("wrap_go", 1'b0, B_H);
    for (int n = 0; n < 17; n++) run_instr("wrap_j", 6'h02, 0, 0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
